// File: rtl/dsp_wb_arbiter.sv
// dsp_wb_arbiter: merges ALU and MAC result streams into a single register-file write port.
// Each source has its own small FIFO. Every cycle at most one head entry is popped, with
// round-robin priority when both FIFOs hold data. Writes to r0 are dropped. The output
// port (we/rw/wdata) is registered.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data      ALU result offer; alu_ready high when its FIFO has room
//   mac_valid/mac_rd/mac_data      MAC result offer; mac_ready high when its FIFO has room
//   we, rw, wdata                  registered register-file write port
//   pending                        per-register flag: a queued or issued write targets it
module dsp_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mac_valid,
  input  logic [3:0]  mac_rd,
  input  logic [31:0] mac_data,
  output logic        mac_ready,
  output logic        we,
  output logic [3:0]  rw,
  output logic [31:0] wdata,
  output logic [15:0] pending
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Channel 0 is the ALU, channel 1 is the MAC.
  logic [3:0]      rd_mem   [2][FIFO_DEPTH];
  logic [31:0]     data_mem [2][FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q   [2];
  logic [PtrW-1:0] rptr_q   [2];
  logic [CntW-1:0] cnt_q    [2];
  logic            last_mac_q;  // 1 when the most recent pop came from the MAC FIFO

  logic [1:0]      ready;
  logic [1:0]      not_empty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [3:0]      head_rd;
  logic [31:0]     head_data;
  logic [PtrW-1:0] idx;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ready[c]     = cnt_q[c] < CntW'(FIFO_DEPTH);
      not_empty[c] = cnt_q[c] != '0;
    end
    // A full FIFO refuses a push even if it pops on the same edge.
    push[0] = alu_valid & ready[0];
    push[1] = mac_valid & ready[1];
    // ALU wins when alone, or on contention when the MAC was granted last.
    pop[0] = not_empty[0] & (~not_empty[1] | last_mac_q);
    pop[1] = not_empty[1] & ~pop[0];
    head_rd   = pop[1] ? rd_mem[1][rptr_q[1]]   : rd_mem[0][rptr_q[0]];
    head_data = pop[1] ? data_mem[1][rptr_q[1]] : data_mem[0][rptr_q[0]];
  end

  assign alu_ready = ready[0];
  assign mac_ready = ready[1];

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push[0]) begin
      rd_mem[0][wptr_q[0]]   <= alu_rd;
      data_mem[0][wptr_q[0]] <= alu_data;
    end
    if (push[1]) begin
      rd_mem[1][wptr_q[1]]   <= mac_rd;
      data_mem[1][wptr_q[1]] <= mac_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      last_mac_q <= 1'b1;
      we         <= 1'b0;
      rw         <= '0;
      wdata      <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + PtrW'(1);
        if (pop[c])  rptr_q[c] <= rptr_q[c] + PtrW'(1);
        if (push[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + CntW'(1);
        end else if (!push[c] && pop[c]) begin
          cnt_q[c] <= cnt_q[c] - CntW'(1);
        end
      end
      if (pop != 2'b00) last_mac_q <= pop[1];
      we <= 1'b0;
      // Entries addressed to r0 are consumed but never written; rw/wdata hold.
      if (pop != 2'b00 && head_rd != 4'd0) begin
        we    <= 1'b1;
        rw    <= head_rd;
        wdata <= head_data;
      end
    end
  end

  // Walk the live window of each FIFO plus the issued write.
  always_comb begin
    pending = '0;
    idx     = '0;
    for (int c = 0; c < 2; c++) begin
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        idx = rptr_q[c] + PtrW'(j);
        if (CntW'(j) < cnt_q[c]) pending[rd_mem[c][idx]] = 1'b1;
      end
    end
    if (we) pending[rw] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_dsp_wb_arbiter.sv
module tb_dsp_wb_arbiter;

  localparam int unsigned Depth = 2;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mac_valid;
  logic [3:0]  alu_rd, mac_rd;
  logic [31:0] alu_data, mac_data;
  logic        alu_ready, mac_ready;
  logic        we;
  logic [3:0]  rw;
  logic [31:0] wdata;
  logic [15:0] pending;

  dsp_wb_arbiter #(.FIFO_DEPTH(Depth)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mac_valid (mac_valid),
    .mac_rd    (mac_rd),
    .mac_data  (mac_data),
    .mac_ready (mac_ready),
    .we        (we),
    .rw        (rw),
    .wdata     (wdata),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Reference model: two queues of outstanding entries and a round-robin flag.
  ent_t aq[$];
  ent_t mq[$];
  ent_t exp_q[$];
  ent_t obs[$];
  bit   m_last_mac = 1'b1;
  bit   m_we = 1'b0;
  logic [3:0] m_rw = '0;
  bit   m_a_ok, m_m_ok, m_popped;
  ent_t m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aq.delete();
      mq.delete();
      exp_q.delete();
      m_we = 1'b0;
      m_last_mac = 1'b1;
    end else begin
      m_a_ok   = alu_valid && (aq.size() < Depth);
      m_m_ok   = mac_valid && (mq.size() < Depth);
      m_popped = 1'b0;
      m_e      = '0;
      if (aq.size() != 0 && (mq.size() == 0 || m_last_mac)) begin
        m_e = aq.pop_front();
        m_last_mac = 1'b0;
        m_popped = 1'b1;
      end else if (mq.size() != 0) begin
        m_e = mq.pop_front();
        m_last_mac = 1'b1;
        m_popped = 1'b1;
      end
      m_we = m_popped && (m_e.rd != 4'd0);
      if (m_we) begin
        m_rw = m_e.rd;
        exp_q.push_back(m_e);
      end
      if (m_a_ok) aq.push_back('{rd: alu_rd, data: alu_data});
      if (m_m_ok) mq.push_back('{rd: mac_rd, data: mac_data});
    end
  end

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = '0;
    foreach (aq[i]) p[aq[i].rd] = 1'b1;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    if (m_we) p[m_rw] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Monitor: sample on the falling edge, pop the scoreboard on every write.
  ent_t got;
  always @(negedge clk) begin
    chk("we_timing", {31'd0, we}, {31'd0, m_we});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, aq.size() < Depth});
    chk("mac_ready", {31'd0, mac_ready}, {31'd0, mq.size() < Depth});
    chk("pending", {16'd0, pending}, {16'd0, model_pending()});
    if (we) begin
      obs.push_back('{rd: rw, data: wdata});
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        got = exp_q.pop_front();
        chk("rw", {28'd0, rw}, {28'd0, got.rd});
        chk("wdata", wdata, got.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int ac, mc;
  bit sa, sm;

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; mac_valid = 1'b0;
    alu_rd = '0; mac_rd = '0; alu_data = '0; mac_data = '0;
    repeat (2) step();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_rw", {28'd0, rw}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_pending", {16'd0, pending}, 32'd0);
    chk("rst_readys", {30'd0, alu_ready, mac_ready}, 32'd3);
    rst = 1'b0;

    // Single ALU write: two-cycle latency and pending tracking.
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'h1234_5678;
    step();
    alu_valid = 1'b0;
    chk("single_pend", {31'd0, pending[3]}, 32'd1);
    chk("single_we0", {31'd0, we}, 32'd0);
    step();
    chk("single_we", {31'd0, we}, 32'd1);
    chk("single_rw", {28'd0, rw}, 32'd3);
    chk("single_wdata", wdata, 32'h1234_5678);
    step();
    chk("single_we_drop", {31'd0, we}, 32'd0);
    chk("single_pend_clr", {16'd0, pending}, 32'd0);

    // r0 writes are swallowed.
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFF_FFFF;
    step();
    alu_valid = 1'b0;
    chk("r0_pend", {16'd0, pending}, 32'd0);
    step();
    chk("r0_we", {31'd0, we}, 32'd0);
    chk("r0_pend2", {16'd0, pending}, 32'd0);

    // Simultaneous offers after reset: ALU first, MAC next.
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'hA;
    mac_valid = 1'b1; mac_rd = 4'd2; mac_data = 32'hB;
    step();
    alu_valid = 1'b0; mac_valid = 1'b0;
    step();
    chk("rr_first_rw", {28'd0, rw}, 32'd1);
    chk("rr_first_data", wdata, 32'hA);
    step();
    chk("rr_second_we", {31'd0, we}, 32'd1);
    chk("rr_second_rw", {28'd0, rw}, 32'd2);
    chk("rr_second_data", wdata, 32'hB);
    repeat (2) step();

    // MAC backpressure under contention.
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h70;
    mac_valid = 1'b1; mac_rd = 4'd8; mac_data = 32'h80;
    step();
    chk("bp_ready_e1", {31'd0, mac_ready}, 32'd1);
    step();
    chk("bp_ready_e2", {31'd0, mac_ready}, 32'd0);
    step();
    chk("bp_ready_e3", {31'd0, mac_ready}, 32'd1);
    alu_valid = 1'b0; mac_valid = 1'b0;
    repeat (6) step();

    // Both channels saturated: alternating grants, per-channel order kept.
    do_reset();
    obs.delete();
    ac = 0; mc = 0;
    alu_valid = 1'b1; alu_rd = 4'd5;
    mac_valid = 1'b1; mac_rd = 4'd6;
    for (int i = 0; i < 12; i++) begin
      alu_data = 32'hA000_0000 + ac;
      mac_data = 32'hB000_0000 + mc;
      sa = alu_ready; sm = mac_ready;
      step();
      if (sa) ac++;
      if (sm) mc++;
    end
    alu_valid = 1'b0; mac_valid = 1'b0;
    repeat (6) step();
    chk("sat_count_ge8", {31'd0, obs.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      chk("sat_order", obs[i].data,
          ((i % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(i / 2));
    end

    // Reset with three entries queued.
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd9;  alu_data = 32'h99;
    mac_valid = 1'b1; mac_rd = 4'd10; mac_data = 32'hAA;
    repeat (2) step();
    alu_valid = 1'b0; mac_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_we", {31'd0, we}, 32'd0);
    chk("midrst_readys", {30'd0, alu_ready, mac_ready}, 32'd3);
    chk("midrst_pending", {16'd0, pending}, 32'd0);
    step();
    rst = 1'b0;
    obs.delete();
    repeat (4) step();
    chk("midrst_no_write", obs.size(), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      alu_valid = ($urandom_range(0, 99) < 70);
      mac_valid = ($urandom_range(0, 99) < 70);
      alu_rd    = 4'($urandom_range(0, 15));
      mac_rd    = 4'($urandom_range(0, 15));
      alu_data  = $urandom;
      mac_data  = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; alu_valid = 1'b0; mac_valid = 1'b0;
    repeat (4 * Depth + 4) step();
    chk("drain_scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_wb_arbiter.md
DSP_WB_ARBITER -- requirements
Module: dsp_wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, per-channel queue depth; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_rd  input  4  ALU destination register index.
REQ-006 alu_data  input  32  ALU result value.
REQ-007 alu_ready  output  1  ALU queue can accept this cycle.
REQ-008 mac_valid  input  1  MAC result offered.
REQ-009 mac_rd  input  4  MAC destination register index.
REQ-010 mac_data  input  32  MAC result value.
REQ-011 mac_ready  output  1  MAC queue can accept this cycle.
REQ-012 we  output  1  register-file write enable, registered.
REQ-013 rw  output  4  register-file write index, registered.
REQ-014 wdata  output  32  register-file write data, registered.
REQ-015 pending  output  16  per-register outstanding-write flags.

Function
REQ-016 Each channel SHALL own an independent FIFO of FIFO_DEPTH entries, each holding {rd, data}.
REQ-017 Push SHALL occur at a rising edge when valid && ready; data/rd SHALL be sampled at that edge.
REQ-018 ready SHALL equal (occupancy < FIFO_DEPTH), based on the occupancy before the edge; a full FIFO SHALL NOT accept a push in the same cycle it pops.
REQ-019 valid asserted while ready is low SHALL have no effect; no data loss or duplication.
REQ-020 Each cycle, at most one head entry SHALL be popped across both FIFOs.
REQ-021 Only one FIFO non-empty: that FIFO SHALL be popped.
REQ-022 Both non-empty: the channel not granted on the most recent pop SHALL be popped (round-robin); last-grant state SHALL update only on a pop.
REQ-023 On a pop with rd != 0, the next edge SHALL register we=1, rw=rd, wdata=data.
REQ-024 On a pop with rd == 0, the entry SHALL be discarded and we SHALL be 0 in the following cycle.
REQ-025 No pop: we SHALL be 0 next cycle; rw and wdata SHALL hold their previous values.
REQ-026 Latency: entry accepted at edge k into an empty, uncontended system SHALL produce we=1 in the cycle after edge k+1 (2 cycles).
REQ-027 Per channel, writes SHALL reach the output in acceptance order; no cross-channel ordering guarantee beyond REQ-022.
REQ-028 Sustained throughput SHALL be one write per cycle total; with both channels saturated, each SHALL receive alternating grants.
REQ-029 pending[i], i in 1..15, SHALL be 1 while any FIFO entry or the registered output (we=1) targets register i; pending[0] SHALL be 0.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked exactly in 0..FIFO_DEPTH.

Reset
REQ-031 rst=1 SHALL immediately clear both FIFOs (occupancy 0) and set we=0, rw=0, wdata=0, pending=0, alu_ready=1, mac_ready=1.
REQ-032 Reset SHALL set last-grant to MAC, so ALU wins the first contention.
REQ-033 Reset mid-operation SHALL discard all queued entries; no write SHALL be issued from pre-reset contents.

Verification
REQ-034 Single ALU push rd=3, data=0x12345678 at edge k -> we=1, rw=3, wdata=0x12345678 in cycle after edge k+1; pending[3]=1 from after edge k until we drops.
REQ-035 Simultaneous ALU rd=1/0xA and MAC rd=2/0xB after reset -> rw=1 then rw=2 on consecutive cycles.
REQ-036 MAC valid held high with output contention, FIFO_DEPTH=2 -> mac_ready=0 after 2 accepted pushes; no third push accepted until a MAC pop.
REQ-037 ALU push rd=0, data=0xFFFFFFFF -> we stays 0; pending remains 0.
REQ-038 Both channels saturated for 8 cycles -> grants alternate ALU, MAC, ALU, ...; each channel's data emerges in push order.
REQ-039 rst asserted with 3 entries queued -> we=0 and readys=1 immediately; no write of queued data after release.
